cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction cache and a data cache.
// Each transaction runs IDLE -> BUSY -> RESP -> IDLE, with a watchdog that aborts a silent memory.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_n;
    logic              owner_dc, owner_dc_n;
    logic              last_dc, last_dc_n;
    logic [7:0]        wait_cnt, wait_cnt_n;
    logic              ic_ready_n, dc_ready_n, mem_req_n, mem_we_n, timeout_err_n;
    logic [DATA_W-1:0] ic_rdata_n, dc_rdata_n, mem_wdata_n;
    logic [ADDR_W-1:0] mem_addr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_dc    <= 1'b0;
            last_dc     <= 1'b0;
            wait_cnt    <= '0;
            ic_ready    <= 1'b0;
            dc_ready    <= 1'b0;
            ic_rdata    <= '0;
            dc_rdata    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            owner_dc    <= owner_dc_n;
            last_dc     <= last_dc_n;
            wait_cnt    <= wait_cnt_n;
            ic_ready    <= ic_ready_n;
            dc_ready    <= dc_ready_n;
            ic_rdata    <= ic_rdata_n;
            dc_rdata    <= dc_rdata_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            timeout_err <= timeout_err_n;
        end
    end

    // Next-state logic also computes the next value of every registered output.
    always_comb begin
        state_n       = state;
        owner_dc_n    = owner_dc;
        last_dc_n     = last_dc;
        wait_cnt_n    = wait_cnt;
        ic_ready_n    = 1'b0;
        dc_ready_n    = 1'b0;
        ic_rdata_n    = ic_rdata;
        dc_rdata_n    = dc_rdata;
        mem_req_n     = mem_req;
        mem_we_n      = mem_we;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        timeout_err_n = timeout_err;

        case (state)
            IDLE: begin
                // On a tie the cache that did not win last time gets the port.
                if (dc_req && (!ic_req || !last_dc)) begin
                    state_n     = BUSY_DC;
                    owner_dc_n  = 1'b1;
                    mem_req_n   = 1'b1;
                    mem_we_n    = dc_we;
                    mem_addr_n  = dc_addr;
                    mem_wdata_n = dc_wdata;
                    wait_cnt_n  = '0;
                end else if (ic_req) begin
                    state_n     = BUSY_IC;
                    owner_dc_n  = 1'b0;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = ic_addr;
                    mem_wdata_n = '0;
                    wait_cnt_n  = '0;
                end
            end

            BUSY_IC, BUSY_DC: begin
                if (mem_ready) begin
                    if (state == BUSY_IC) ic_rdata_n = mem_rdata;
                    else if (!mem_we)     dc_rdata_n = mem_rdata;
                    mem_req_n = 1'b0;
                    state_n   = RESP;
                end else if (wait_cnt == TO_LAST) begin
                    // Memory never answered: complete with zero data and flag it.
                    if (state == BUSY_IC) ic_rdata_n = '0;
                    else if (!mem_we)     dc_rdata_n = '0;
                    timeout_err_n = 1'b1;
                    mem_req_n     = 1'b0;
                    state_n       = RESP;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end

            RESP: begin
                ic_ready_n = !owner_dc;
                dc_ready_n = owner_dc;
                last_dc_n  = owner_dc;
                wait_cnt_n = '0;
                state_n    = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized self-checking bench for cache_mem_arbiter; a transaction-level model predicts
// the grant winner, memory request fields and the read data each cache should hold.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, ic_ready, dc_req, dc_we, dc_ready;
    logic [15:0] ic_addr, dc_addr, mem_addr;
    logic [31:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_ready, timeout_err;

    int errors = 0;
    int checks = 0;

    logic        last_dc_m;
    logic [31:0] m_ic_rdata, m_dc_rdata;

    typedef struct packed {
        logic        got;
        int          wait_n;
        logic [15:0] a;
        logic        we;
        logic [31:0] wd;
        logic        stable;
        logic        early_ok;
        logic        ic_r;
        logic        dc_r;
        logic [31:0] ic_rd;
        logic [31:0] dc_rd;
        logic        one_shot;
    } obs_t;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        ic_req = 0; dc_req = 0; dc_we = 0; mem_ready = 0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_dc_m = 1'b0;
        m_ic_rdata = '0;
        m_dc_rdata = '0;
    endtask

    // Plays the memory side of one transaction and records what the arbiter did.
    task automatic run_txn(input int lat, input logic [31:0] rd, input bit drop_mid,
                           input bit drop_rdy, output obs_t o);
        o = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                o.got = 1'b1;
                o.wait_n = i;
                break;
            end
        end
        if (!o.got) return;
        o.a = mem_addr; o.we = mem_we; o.wd = mem_wdata; o.stable = 1'b1;
        if (drop_mid) begin ic_req = 0; dc_req = 0; end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || mem_addr !== o.a || mem_we !== o.we || mem_wdata !== o.wd)
                o.stable = 1'b0;
        end
        mem_rdata = rd; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = $urandom;
        o.early_ok = (mem_req === 1'b0 && ic_ready === 1'b0 && dc_ready === 1'b0);
        @(negedge clk);
        o.ic_r = ic_ready; o.dc_r = dc_ready; o.ic_rd = ic_rdata; o.dc_rd = dc_rdata;
        if (drop_rdy) begin
            if (ic_ready === 1'b1) ic_req = 0;
            if (dc_ready === 1'b1) dc_req = 0;
        end
        @(negedge clk);
        o.one_shot = (ic_ready === 1'b0 && dc_ready === 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, ic_rdata, dc_rdata, timeout_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h icr=%b dcr=%b icd=%h dcd=%h to=%b expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, ic_ready, dc_ready, ic_rdata, dc_rdata, timeout_err);
        end
    endtask

    task automatic test_ic_read();
        obs_t o;
        ic_addr = 16'h0010; ic_req = 1;
        run_txn(0, 32'h8C220004, 0, 1, o);
        checks++; if (o.got !== 1'b1 || o.wait_n != 1) begin errors++; $display("[TB] FAIL ic_grant_latency: got=%b wait=%0d expected 1/1", o.got, o.wait_n); end
        checks++; if (o.a !== 16'h0010 || o.we !== 1'b0) begin errors++; $display("[TB] FAIL ic_mem_fields: addr=%h we=%b expected 0010/0", o.a, o.we); end
        checks++; if (o.early_ok !== 1'b1) begin errors++; $display("[TB] FAIL ic_resp_cycle: got %b expected 1", o.early_ok); end
        checks++; if (o.ic_r !== 1'b1 || o.dc_r !== 1'b0) begin errors++; $display("[TB] FAIL ic_ready_pulse: ic=%b dc=%b expected 1/0", o.ic_r, o.dc_r); end
        checks++; if (o.ic_rd !== 32'h8C220004) begin errors++; $display("[TB] FAIL ic_rdata: got %h expected 8c220004", o.ic_rd); end
        checks++; if (o.one_shot !== 1'b1) begin errors++; $display("[TB] FAIL ic_ready_width: got %b expected 1", o.one_shot); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ic_no_regrant: mem_req=%b expected 0", mem_req); end
        m_ic_rdata = 32'h8C220004;
        last_dc_m = 1'b0;
    endtask

    task automatic test_dc_write();
        obs_t o;
        dc_we = 0; dc_addr = 16'h0100; dc_req = 1;
        run_txn(1, 32'h12345678, 0, 1, o);
        checks++; if (o.dc_rd !== 32'h12345678 || o.dc_r !== 1'b1) begin errors++; $display("[TB] FAIL dc_read_setup: rdata=%h rdy=%b expected 12345678/1", o.dc_rd, o.dc_r); end
        m_dc_rdata = 32'h12345678;
        dc_we = 1; dc_addr = 16'h0200; dc_wdata = 32'hDEADBEEF; dc_req = 1;
        run_txn(4, 32'h5555AAAA, 0, 1, o);
        checks++; if (o.a !== 16'h0200 || o.we !== 1'b1 || o.wd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL dc_write_fields: addr=%h we=%b wd=%h expected 0200/1/deadbeef", o.a, o.we, o.wd); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("[TB] FAIL dc_write_stable: got %b expected 1", o.stable); end
        checks++; if (o.dc_r !== 1'b1 || o.ic_r !== 1'b0) begin errors++; $display("[TB] FAIL dc_write_ready: dc=%b ic=%b expected 1/0", o.dc_r, o.ic_r); end
        checks++; if (o.dc_rd !== m_dc_rdata) begin errors++; $display("[TB] FAIL dc_write_rdata_hold: got %h expected %h", o.dc_rd, m_dc_rdata); end
        last_dc_m = 1'b1;
    endtask

    task automatic test_idle_ready();
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1; mem_rdata = $urandom;
            @(negedge clk);
            if (mem_req !== 1'b0 || ic_ready !== 1'b0 || dc_ready !== 1'b0 ||
                ic_rdata !== m_ic_rdata || dc_rdata !== m_dc_rdata) bad++;
        end
        mem_ready = 0;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL idle_mem_ready_ignored: bad cycles=%0d expected 0", bad); end
    endtask

    task automatic test_drop_mid();
        obs_t o;
        ic_addr = 16'h0ABC; ic_req = 1;
        run_txn(2, 32'hCAFEF00D, 1, 1, o);
        checks++; if (o.ic_r !== 1'b1 || o.ic_rd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL drop_mid_completes: rdy=%b rdata=%h expected 1/cafef00d", o.ic_r, o.ic_rd); end
        m_ic_rdata = 32'hCAFEF00D;
        last_dc_m = 1'b0;
    endtask

    task automatic test_round_robin();
        obs_t o;
        logic exp_dc;
        logic [31:0] rd;
        do_reset();
        ic_addr = 16'h1111; dc_addr = 16'h2222; dc_we = 0; ic_req = 1; dc_req = 1;
        for (int t = 0; t < 5; t++) begin
            exp_dc = (t % 2 == 0);
            rd = $urandom;
            if (t == 4) begin ic_req = 0; dc_req = 0; end
            run_txn(0, rd, 0, 0, o);
            if (exp_dc) m_dc_rdata = rd; else m_ic_rdata = rd;
            checks++; if (o.a !== (exp_dc ? 16'h2222 : 16'h1111)) begin errors++; $display("[TB] FAIL rr_grant_%0d: addr=%h expected %h", t, o.a, exp_dc ? 16'h2222 : 16'h1111); end
            checks++; if (o.dc_r !== exp_dc || o.ic_r !== !exp_dc) begin errors++; $display("[TB] FAIL rr_ready_%0d: ic=%b dc=%b expected dc=%b", t, o.ic_r, o.dc_r, exp_dc); end
        end
        last_dc_m = 1'b1;
    endtask

    task automatic test_random();
        obs_t o;
        int p, lat, n;
        logic win_dc, dwe;
        logic [15:0] ia, da;
        logic [31:0] dwd, rd;
        for (int it = 0; it < 40; it++) begin
            p = $urandom_range(1, 3);
            ia = 16'($urandom); da = 16'($urandom); dwd = $urandom; dwe = 1'($urandom);
            ic_addr = ia; dc_addr = da; dc_wdata = dwd; dc_we = dwe;
            ic_req = (p != 2); dc_req = (p != 1);
            win_dc = (p == 3) ? !last_dc_m : (p == 2);
            n = (p == 3) ? 2 : 1;
            for (int t = 0; t < n; t++) begin
                lat = $urandom_range(0, 4);
                rd = $urandom;
                run_txn(lat, rd, 0, 1, o);
                if (win_dc && !dwe) m_dc_rdata = rd;
                if (!win_dc) m_ic_rdata = rd;
                last_dc_m = win_dc;
                checks++;
                if (o.got !== 1'b1 || o.a !== (win_dc ? da : ia) || o.we !== (win_dc ? dwe : 1'b0) ||
                    (win_dc && o.wd !== dwd) || o.stable !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand_req_%0d_%0d: got=%b addr=%h we=%b wd=%h stable=%b expected dc=%b addr=%h",
                             it, t, o.got, o.a, o.we, o.wd, o.stable, win_dc, win_dc ? da : ia);
                end
                checks++;
                if (o.early_ok !== 1'b1 || o.dc_r !== win_dc || o.ic_r !== !win_dc || o.one_shot !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand_ready_%0d_%0d: early=%b ic=%b dc=%b one=%b expected dc=%b",
                             it, t, o.early_ok, o.ic_r, o.dc_r, o.one_shot, win_dc);
                end
                checks++;
                if (o.ic_rd !== m_ic_rdata || o.dc_rd !== m_dc_rdata) begin
                    errors++;
                    $display("[TB] FAIL rand_rdata_%0d_%0d: ic=%h dc=%h expected ic=%h dc=%h",
                             it, t, o.ic_rd, o.dc_rd, m_ic_rdata, m_dc_rdata);
                end
                win_dc = !win_dc;
            end
            checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rand_no_regrant_%0d: mem_req=%b expected 0", it, mem_req); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        int cnt = 0;
        dc_we = 0; dc_addr = 16'h0300; dc_req = 1;
        run_txn(0, 32'hA5A5A5A5, 0, 1, o);
        checks++; if (o.dc_rd !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL timeout_setup: got %h expected a5a5a5a5", o.dc_rd); end
        dc_addr = 16'h0304; dc_req = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        checks++; if (cnt != 255) begin errors++; $display("[TB] FAIL timeout_busy_cycles: got %0d expected 255", cnt); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %b expected 1", timeout_err); end
        @(negedge clk);
        checks++; if (dc_ready !== 1'b1 || dc_rdata !== 32'h0) begin errors++; $display("[TB] FAIL timeout_resp: rdy=%b rdata=%h expected 1/0", dc_ready, dc_rdata); end
        dc_req = 0;
        m_dc_rdata = '0;
        ic_addr = 16'h0042; ic_req = 1;
        run_txn(1, 32'h0BADF00D, 0, 1, o);
        checks++; if (timeout_err !== 1'b1 || o.ic_rd !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL timeout_sticky: flag=%b rdata=%h expected 1/0badf00d", timeout_err, o.ic_rd); end
        do_reset();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear_on_reset: got %b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int pulses = 0;
        ic_addr = 16'h0777; ic_req = 1;
        for (int i = 0; i < 5 && mem_req !== 1'b1; i++) @(negedge clk);
        rst = 1; ic_req = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || ic_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_abort: mem_req=%b ic_ready=%b expected 0/0", mem_req, ic_ready); end
        rst = 0;
        last_dc_m = 0; m_ic_rdata = '0; m_dc_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ic_ready === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL reset_no_ready: pulses=%0d expected 0", pulses); end
        dc_we = 0; dc_addr = 16'h0888; dc_req = 1;
        run_txn(0, 32'h13579BDF, 0, 1, o);
        checks++; if (o.a !== 16'h0888 || o.dc_r !== 1'b1 || o.dc_rd !== 32'h13579BDF || o.ic_rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_then_dc: addr=%h rdy=%b dc=%h ic=%h expected 0888/1/13579bdf/0", o.a, o.dc_r, o.dc_rd, o.ic_rd);
        end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_idle_ready();
        test_drop_mid();
        test_round_robin();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
